// File: rtl/reg_pipe_pkg.sv
// Purpose: shared constants and helpers for the reg_pipe register pipeline.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package reg_pipe_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 4;

   // Ceiling log2, never below 1 so a counter always has at least one bit.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      if (result == 0) begin
         result = 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/reg_pipe_if.sv
// Purpose: bus bundle for reg_pipe; master drives en/flush/d/d_valid, slave returns q/q_valid/count.
// Latency: n/a (wiring only).
// Backpressure: none; en is a hold control, not a ready handshake.
interface reg_pipe_if
   import reg_pipe_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int CW    = clog2(DEPTH + 1)
) ();

   logic             en;
   logic             flush;
   logic [WIDTH-1:0] d;
   logic             d_valid;
   logic [WIDTH-1:0] q;
   logic             q_valid;
   logic [CW-1:0]    count;

   modport master (
      output en, flush, d, d_valid,
      input  q, q_valid, count
   );

   modport slave (
      input  en, flush, d, d_valid,
      output q, q_valid, count
   );

endinterface

// File: rtl/dff_en_stage.sv
// Purpose: one pipeline register (data plus valid) with async reset, sync clear and sync enable.
// Latency: 1 enabled edge from din to dout.
// Backpressure: en=0 holds the stored value; clr overrides en.
// Ports: clk, reset (async, active-high), en, clr, din[W-1:0], dout[W-1:0].
module dff_en_stage #(
   parameter int           W         = 9,
   parameter logic [W-1:0] RESET_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout <= RESET_VAL;
      end else if (clr) begin
         dout <= RESET_VAL;
      end else if (en) begin
         dout <= din;
      end
   end

endmodule

// File: rtl/reg_pipe.sv
// Purpose: DEPTH-stage enabled register pipeline with per-stage valid and a running occupancy count.
// Latency: DEPTH enabled edges from d to q; disabled edges add no shift.
// Backpressure: en=0 freezes all stages and count; flush clears everything and wins over en.
// Ports: clk, reset (async, active-high), bus (reg_pipe_if.slave: en, flush, d, d_valid -> q, q_valid, count).
module reg_pipe
   import reg_pipe_pkg::*;
#(
   parameter int               WIDTH     = DEFAULT_WIDTH,
   parameter int               DEPTH     = DEFAULT_DEPTH,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input logic       clk,
   input logic       reset,
   reg_pipe_if.slave bus
);

   localparam int CW = clog2(DEPTH + 1);

   // Each stage carries {data, valid}; valid sits in bit 0.
   logic [WIDTH:0] stage_in  [DEPTH];
   logic [WIDTH:0] stage_out [DEPTH];
   logic [CW-1:0]  count_r;
   logic           last_valid;

   assign stage_in[0] = {bus.d, bus.d_valid};

   genvar i;
   generate
      for (i = 0; i < DEPTH; i++) begin : g_stage
         if (i > 0) begin : g_link
            assign stage_in[i] = stage_out[i-1];
         end
         dff_en_stage #(
            .W         (WIDTH + 1),
            .RESET_VAL ({RESET_VAL, 1'b0})
         ) u_stage (
            .clk   (clk),
            .reset (reset),
            .en    (bus.en),
            .clr   (bus.flush),
            .din   (stage_in[i]),
            .dout  (stage_out[i])
         );
      end
   endgenerate

   assign last_valid = stage_out[DEPTH-1][0];

   // Occupancy tracks popcount(valid) incrementally: on a shift one valid bit
   // enters at stage 0 and one leaves from the last stage, so only the
   // mismatched cases change the total.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r <= '0;
      end else if (bus.flush) begin
         count_r <= '0;
      end else if (bus.en) begin
         if (bus.d_valid && !last_valid) begin
            count_r <= count_r + CW'(1);
         end else if (!bus.d_valid && last_valid) begin
            count_r <= count_r - CW'(1);
         end
      end
   end

   assign bus.q       = stage_out[DEPTH-1][WIDTH:1];
   assign bus.q_valid = last_valid;
   assign bus.count   = count_r;

endmodule

// File: tb/tb_reg_pipe.sv
// Purpose: self-checking bench for reg_pipe (WIDTH=8, DEPTH=4) with directed and random stimulus.
// Latency: expects q to reflect the word entered DEPTH enabled edges earlier.
// Backpressure: exercises en=0 holds, flush and async reset against a history model.
module tb_reg_pipe;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;

   logic clk;
   logic reset;

   int checks = 0;
   int errors = 0;

   // Reference: history of words entered on enabled edges, newest first.
   // q is simply the entry DEPTH edges old; count is the number of valid
   // words among the last DEPTH entered.
   logic [WIDTH:0] hist [$];

   reg_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bif ();

   reg_pipe #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .RESET_VAL (8'h00)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_clear();
      hist.delete();
      for (int k = 0; k < DEPTH; k++) begin
         hist.push_back({8'h00, 1'b0});
      end
   endtask

   task automatic model_edge(input logic e, input logic f, input logic [WIDTH-1:0] dd, input logic dv);
      if (f) begin
         model_clear();
      end else if (e) begin
         hist.push_front({dd, dv});
         void'(hist.pop_back());
      end
   endtask

   function automatic int model_count();
      int n;
      n = 0;
      foreach (hist[k]) begin
         n += int'(hist[k][0]);
      end
      return n;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".q"},       32'(bif.q),       32'(hist[DEPTH-1][WIDTH:1]));
      check({tag, ".q_valid"}, 32'(bif.q_valid), 32'(hist[DEPTH-1][0]));
      check({tag, ".count"},   32'(bif.count),   32'(model_count()));
   endtask

   task automatic step(input logic e, input logic f, input logic [WIDTH-1:0] dd, input logic dv, input string tag);
      bif.en      = e;
      bif.flush   = f;
      bif.d       = dd;
      bif.d_valid = dv;
      @(posedge clk);
      model_edge(e, f, dd, dv);
      #1;
      check_model(tag);
   endtask

   initial begin
      model_clear();
      reset       = 1'b1;
      bif.en      = 1'b1;
      bif.flush   = 1'b0;
      bif.d       = 8'hFF;
      bif.d_valid = 1'b1;
      #1;
      check("rst_init.q", 32'(bif.q), 32'h00);
      check("rst_init.q_valid", 32'(bif.q_valid), 32'h0);
      check("rst_init.count", 32'(bif.count), 32'h0);

      // Reset held with clocks running and live inputs.
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check("rst_hold.q", 32'(bif.q), 32'h00);
         check("rst_hold.q_valid", 32'(bif.q_valid), 32'h0);
         check("rst_hold.count", 32'(bif.count), 32'h0);
      end
      reset = 1'b0;

      // Latency: first word exits on the 4th enabled edge.
      step(1'b1, 1'b0, 8'hA1, 1'b1, "lat1");
      step(1'b1, 1'b0, 8'hA2, 1'b1, "lat2");
      step(1'b1, 1'b0, 8'hA3, 1'b1, "lat3");
      check("lat3.q_valid_early", 32'(bif.q_valid), 32'h0);
      step(1'b1, 1'b0, 8'hA4, 1'b1, "lat4");
      check("lat.q_a1", 32'(bif.q), 32'hA1);
      check("lat.q_valid", 32'(bif.q_valid), 32'h1);
      check("lat.count4", 32'(bif.count), 32'h4);

      // Stall: two words, five held edges, then drain.
      step(1'b0, 1'b1, 8'h00, 1'b0, "stall_flush");
      step(1'b1, 1'b0, 8'hB1, 1'b1, "stall_ld1");
      step(1'b1, 1'b0, 8'hB2, 1'b1, "stall_ld2");
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b0, 8'($urandom), 1'b1, "stall_hold");
         check("stall.count2", 32'(bif.count), 32'h2);
      end
      step(1'b1, 1'b0, 8'h00, 1'b0, "stall_res1");
      step(1'b1, 1'b0, 8'h00, 1'b0, "stall_res2");
      check("stall.q_b1", 32'(bif.q), 32'hB1);
      check("stall.q_valid_b1", 32'(bif.q_valid), 32'h1);
      step(1'b1, 1'b0, 8'h00, 1'b0, "stall_res3");
      check("stall.q_b2", 32'(bif.q), 32'hB2);

      // Bubbles: alternating valid.
      step(1'b0, 1'b1, 8'h00, 1'b0, "bub_flush");
      for (int k = 1; k <= 10; k++) begin
         step(1'b1, 1'b0, 8'(8'hC0 + k), (k % 2) == 1, "bub");
         if (k >= 4) begin
            check("bub.q_valid_pat", 32'(bif.q_valid), 32'((k - 3) % 2));
            check("bub.count_le2", 32'(bif.count <= 3'd2), 32'h1);
         end
      end

      // Flush of a full pipeline wins over en with a valid input.
      for (int k = 0; k < DEPTH; k++) begin
         step(1'b1, 1'b0, 8'(8'hE0 + k), 1'b1, "fl_fill");
      end
      check("fl.count_full", 32'(bif.count), 32'h4);
      step(1'b1, 1'b1, 8'hCC, 1'b1, "fl_flush");
      check("fl.count0", 32'(bif.count), 32'h0);
      check("fl.q_valid0", 32'(bif.q_valid), 32'h0);
      check("fl.q_reset", 32'(bif.q), 32'h00);

      // Async reset between edges with three words in flight.
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b0, 8'(8'hD0 + k), 1'b1, "ar_fill");
      end
      check("ar.count3", 32'(bif.count), 32'h3);
      #2;
      reset = 1'b1;
      #1;
      check("ar.q", 32'(bif.q), 32'h00);
      check("ar.q_valid", 32'(bif.q_valid), 32'h0);
      check("ar.count", 32'(bif.count), 32'h0);
      model_clear();
      #2;
      reset = 1'b0;
      step(1'b1, 1'b0, 8'hD5, 1'b1, "ar_push");
      check("ar.count1", 32'(bif.count), 32'h1);
      check("ar.q_valid_after", 32'(bif.q_valid), 32'h0);

      // Random traffic with occasional flush and async reset.
      for (int n = 0; n < 400; n++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
              8'($urandom), 1'($urandom_range(0, 1)), "rnd");
         if ((n % 97) == 50) begin
            #2;
            reset = 1'b1;
            #1;
            model_clear();
            check_model("rnd_rst");
            #2;
            reset = 1'b0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_pipe.md
REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per stage (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (>=1).
REQ-003 SHALL have parameter RESET_VAL, default 0, value loaded into every data stage on reset and flush.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port en, input, 1, synchronous enable; 1 = advance pipeline, 0 = hold.
REQ-007 SHALL have port flush, input, 1, synchronous clear of all stages.
REQ-008 SHALL have port d, input, WIDTH, data into stage 0.
REQ-009 SHALL have port d_valid, input, 1, qualifies d.
REQ-010 SHALL have port q, output, WIDTH, data of stage DEPTH-1.
REQ-011 SHALL have port q_valid, output, 1, valid bit of stage DEPTH-1.
REQ-012 SHALL have port count, output, CW = clog2(DEPTH+1), number of stages holding valid data.

Function
REQ-013 Each stage i SHALL hold data[i] (WIDTH) and valid[i] (1); q/q_valid driven directly from stage DEPTH-1 registers, no combinational path from inputs.
REQ-014 Edge with flush=0, en=1: data[0]<=d, valid[0]<=d_valid, data[i]<=data[i-1], valid[i]<=valid[i-1] for i=1..DEPTH-1.
REQ-015 Edge with flush=0, en=0: all data, valid and count SHALL hold.
REQ-016 Edge with flush=1: all data<=RESET_VAL, all valid<=0, count<=0, regardless of en, d, d_valid.
REQ-017 Latency: a word presented with en=1 SHALL appear on q after exactly DEPTH enabled edges; disabled edges add no shift.
REQ-018 Data SHALL shift on en=1 regardless of d_valid; invalid words propagate as bubbles with valid=0.
REQ-019 count SHALL be a register updated each enabled edge: +1 if d_valid=1 and valid[DEPTH-1]=0, -1 if d_valid=0 and valid[DEPTH-1]=1, else unchanged.
REQ-020 count SHALL equal popcount(valid) after every edge; range 0..DEPTH, never wraps.
REQ-021 DEPTH=1: SHALL behave as a single enabled DFF with valid bit; count in {0,1}.
REQ-022 flush and en both 1 on the same edge: flush wins; the input word is discarded.

Reset
REQ-023 reset=1 SHALL immediately (no clock) force data=RESET_VAL, valid=0, count=0, hence q=RESET_VAL, q_valid=0.
REQ-024 Reset asserted mid-stream SHALL discard all in-flight words; first edge after release with en=1 SHALL load stage 0 only.
REQ-025 Reset SHALL have priority over flush and en.

Structure
REQ-026 Shared package reg_pipe_pkg SHALL hold default WIDTH/DEPTH constants and the clog2 function used for CW.
REQ-027 One sub-module dff_en_stage (WIDTH+1 bits: data plus valid, async reset, sync enable, sync clear) SHALL be instantiated DEPTH times via generate; count logic lives in reg_pipe.

Verification
REQ-028 Reset: reset=1 with d=8'hFF, en=1, clocks running -> q=8'h00, q_valid=0, count=0 throughout.
REQ-029 Latency: WIDTH=8, DEPTH=4, en=1, push 8'hA1,A2,A3,A4 valid -> q=8'hA1 with q_valid=1 on 4th edge after first push; count=4 then.
REQ-030 Stall: load 2 valid words, hold en=0 for 5 edges -> q, q_valid, count (=2) unchanged; resume en=1 -> words exit in order after 2 more edges.
REQ-031 Bubbles: alternate d_valid 1,0,1,0 with en=1 -> q_valid pattern 1,0,1,0 from edge 4; count never exceeds 2 after steady state.
REQ-032 Flush: pipeline full (count=4), assert flush=1 with en=1, d_valid=1 -> next edge count=0, q_valid=0, q=RESET_VAL.
REQ-033 Async reset mid-operation: assert reset between edges with count=3 -> outputs clear before next edge; after release, one valid push -> count=1.
